// File: rtl/conv_pkg.sv
// Shared bf16 field layout, E8M0 constants and FSM state encoding for the
// bf16 -> block fixed-point converter.
package conv_pkg;

    localparam int BF16_W        = 16;
    localparam int BF16_MAN_W    = 7;
    localparam int BF16_EXP_W    = 8;
    localparam int BF16_MAN_LSB  = 0;
    localparam int BF16_EXP_LSB  = 7;
    localparam int BF16_SIGN_BIT = 15;
    localparam int BF16_EXP_BIAS = 127;

    localparam logic [7:0] BF16_EXP_MAX = 8'hFF;
    localparam logic [7:0] E8M0_NAN     = 8'hFF;

    typedef enum logic {
        ST_FILL  = 1'b0,
        ST_DRAIN = 1'b1
    } conv_state_e;

    function automatic logic [BF16_EXP_W-1:0] bf16_exp(input logic [BF16_W-1:0] x);
        return x[BF16_EXP_LSB +: BF16_EXP_W];
    endfunction

endpackage

// File: rtl/conv_bf16tofi_elem.sv
// Combinational align/negate of one bf16 element against the block maximum
// exponent, truncating toward zero into a bit_width two's-complement value.
module conv_bf16tofi_elem
    import conv_pkg::*;
#(
    parameter int bit_width = 8
) (
    input  logic [BF16_W-1:0]     bf16,
    input  logic [7:0]            max_e,
    output logic [bit_width-1:0]  fi_num
);

    logic [7:0]           exp_f;
    logic [8:0]           mant;
    logic [9:0]           sh;
    logic [bit_width-1:0] mag;

    // 1.m has 7 fraction bits and the output keeps bit_width-2, so the
    // right shift is the exponent gap plus (9 - bit_width).
    always_comb begin
        exp_f = bf16_exp(bf16);
        mant  = {2'b01, bf16[BF16_MAN_LSB +: BF16_MAN_W]};
        sh    = {2'b00, max_e} - {2'b00, exp_f} + 10'(9 - bit_width);
        if (exp_f == 8'd0 || sh >= 10'd8) begin
            mag = '0;
        end else begin
            mag = bit_width'(mant >> sh[2:0]);
        end
        fi_num = bf16[BF16_SIGN_BIT] ? -mag : mag;
    end

endmodule

// File: rtl/conv_bf16tofi_blk.sv
// Collects blk_size bf16 elements, then streams them out as fixed-point values
// sharing one E8M0 scale. Define CONV_BF16TOFI_NAN_EN to flag exponent-255 blocks as NaN.
module conv_bf16tofi_blk
    import conv_pkg::*;
#(
    parameter int bit_width = 8,
    parameter int blk_size  = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [15:0]           i_bf16,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [bit_width-1:0]  o_fi_num,
    output logic [7:0]            o_scale,
    output logic                  o_last
);

    localparam int IDX_W = (blk_size > 1) ? $clog2(blk_size) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(blk_size - 1);

    conv_state_e          state_q;
    logic [IDX_W-1:0]     idx_q;
    logic [7:0]           max_e_q;
    logic [15:0]          buf_q [blk_size];
    logic [7:0]           in_exp;
    logic                 fill_hs;
    logic                 nan_blk;
    logic [bit_width-1:0] elem_fi;

    assign in_exp  = bf16_exp(i_bf16);
    assign fill_hs = (state_q == ST_FILL) && i_valid;

    // Element storage needs no reset: it is always written before it is read.
    always_ff @(posedge i_clk) begin
        if (fill_hs) begin
            buf_q[idx_q] <= i_bf16;
        end
    end

`ifdef CONV_BF16TOFI_NAN_EN
    logic nan_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            nan_q <= 1'b0;
        end else if (fill_hs && in_exp == BF16_EXP_MAX) begin
            nan_q <= 1'b1;
        end else if (state_q == ST_DRAIN && i_ready && idx_q == LAST_IDX) begin
            nan_q <= 1'b0;
        end
    end

    assign nan_blk = nan_q;
`else
    assign nan_blk = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_FILL;
            idx_q   <= '0;
            max_e_q <= 8'd0;
        end else begin
            case (state_q)
                ST_FILL: begin
                    if (i_valid) begin
                        if (in_exp > max_e_q) begin
                            max_e_q <= in_exp;
                        end
                        if (idx_q == LAST_IDX) begin
                            idx_q   <= '0;
                            state_q <= ST_DRAIN;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (i_ready) begin
                        if (idx_q == LAST_IDX) begin
                            idx_q   <= '0;
                            max_e_q <= 8'd0;
                            state_q <= ST_FILL;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                default: state_q <= ST_FILL;
            endcase
        end
    end

    conv_bf16tofi_elem #(
        .bit_width (bit_width)
    ) u_elem (
        .bf16   (buf_q[idx_q]),
        .max_e  (max_e_q),
        .fi_num (elem_fi)
    );

    // Outputs are driven purely from held state, so they cannot move during a stall.
    assign o_ready  = (state_q == ST_FILL);
    assign o_valid  = (state_q == ST_DRAIN);
    assign o_last   = o_valid && (idx_q == LAST_IDX);
    assign o_scale  = !o_valid ? 8'd0 : (nan_blk ? E8M0_NAN : max_e_q);
    assign o_fi_num = (o_valid && !nan_blk) ? elem_fi : '0;

endmodule
